countup_timer: RTL
==================

Name: countup_timer

Overview:
Elapsed-time stopwatch for the digital clock. It is the count-up counterpart of the countdown counter.
- An internal prescaler turns i_clk into one-second ticks.
- The ticks drive cascaded seconds/minutes/hours counters, starting at zero.
- The counters count up toward a programmable target.
- A small run-control FSM handles start, stop and clear, and signals completion.
- Outputs feed the 7-segment display path and the alarm/buzzer logic.

Parameters:
TICK_DIV, 50000000, i_clk cycles per one-second tick (must be >= 2)
SEC_MAX, 59, terminal value of seconds field
MIN_MAX, 59, terminal value of minutes field
HOUR_MAX, 99, terminal value of hours field

Ports:
i_clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
i_start  input  1  start/resume request, level sampled each edge
i_stop  input  1  pause request, level sampled each edge
i_clear  input  1  return to zero and IDLE
i_limit_hour  input  7  target hours
i_limit_min  input  7  target minutes
i_limit_sec  input  7  target seconds
o_hour  output  7  elapsed hours
o_min  output  7  elapsed minutes
o_sec  output  7  elapsed seconds
o_running  output  1  high while state is RUN
o_tick  output  1  one-cycle pulse, high in the cycle after counts advance
o_done  output  1  one-cycle pulse on target match
o_wrap  output  1  one-cycle pulse when HOUR_MAX:MIN_MAX:SEC_MAX rolls to 0:0:0

Behaviour:
Reset:
- Registers: state=IDLE; prescaler=0; o_hour/o_min/o_sec=0.
- Outputs: o_running=0, o_tick=0, o_done=0, o_wrap=0.

FSM states and transitions:
- States: IDLE, RUN, PAUSE, DONE.
- Control priority per edge: reset > i_clear > i_stop > i_start.
- i_clear (any state): counts=0, prescaler=0, state->IDLE.
- i_stop in RUN: state->PAUSE. Prescaler and counts hold; any tick due on that edge is dropped.
- i_stop in other states: ignored.
- i_start in IDLE: state->RUN, prescaler=0.
- i_start in PAUSE: state->RUN, prescaler keeps its paused value.
- i_start in RUN: ignored.
- i_start in DONE: ignored; i_clear is required to leave DONE.
- i_start and i_stop in the same cycle: stop wins (RUN->PAUSE; IDLE/PAUSE stay put).

Prescaler:
- Advances only on edges where the pre-edge state is RUN and no clear/stop is applied.
- At TICK_DIV-1 it wraps to 0 and advances the counts on the same edge.
- Timing: start sampled at edge E0 gives o_sec=1 after edge E(TICK_DIV).

Count advance (on a tick edge):
- sec<SEC_MAX: sec+1.
- Else sec=0 and, in the same edge, min<MIN_MAX: min+1; else min=0 and hour+1.
- At full terminal value all fields go to 0, and o_wrap pulses in the next cycle.
- Fields never exceed their MAX values.

Target match:
- Evaluated on the post-increment value.
- If the new {hour,min,sec} equals the limits and the limits are not all zero: state->DONE and counts freeze at the target.
- In that case o_done pulses in the cycle after the edge, aligned with o_tick.
- Limit 0:0:0 means free-run: no match, wrap allowed.
- Limits above MAX never match, so the timer free-runs.
- A target of MAX:MAX:MAX matches; no wrap occurs.
- Limits are sampled live. A limit changed to a value below the current count does not match until after the next wrap.

Output timing:
- o_tick, o_done and o_wrap are registered single-cycle pulses.
- Each pulse is cleared on the following edge.
- reset or i_clear forces them to 0 on that edge.

Test Plan:
Directed scenarios (TICK_DIV=4 for simulation):
- Reset, then i_start for 1 cycle, limits 0:0:0: o_sec=1 exactly 4 edges after start; o_tick pulses 1 cycle; o_running=1.
- Run to 0:0:59, then one more tick: next count is 0:1:0. Preload near HOUR_MAX, reach 99:59:59, next tick: 0:0:0 with o_wrap=1 for 1 cycle.
- Limits 0:0:3, start: counts stop at 0:0:3 with o_done=1 for 1 cycle and o_running=0; later i_start is ignored; i_clear gives 0:0:0 in IDLE.
- Start, assert i_stop 2 edges in (prescaler=2); hold 10 cycles with counts frozen; i_start resumes: next tick arrives exactly 2 edges later.
- Same-cycle i_start+i_stop while RUN gives PAUSE. Same-cycle i_clear+i_start gives IDLE at 0:0:0. i_stop coincident with a tick edge: count not advanced.
- reset asserted mid-RUN at 0:5:17: next edge gives all outputs 0, state IDLE; a tick due that edge is discarded.

Source files
------------

// File: rtl/countup_timer.sv
// countup_timer: elapsed-time stopwatch. A prescaler divides i_clk into
// one-second ticks that advance cascaded sec/min/hour fields toward a
// programmable target. A small run-control FSM handles start/stop/clear and
// raises single-cycle tick/done/wrap pulses for the display and alarm paths.
module countup_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int SEC_MAX  = 59,
  parameter int MIN_MAX  = 59,
  parameter int HOUR_MAX = 99
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_clear,
  input  logic [6:0] i_limit_hour,
  input  logic [6:0] i_limit_min,
  input  logic [6:0] i_limit_sec,
  output logic [6:0] o_hour,
  output logic [6:0] o_min,
  output logic [6:0] o_sec,
  output logic       o_running,
  output logic       o_tick,
  output logic       o_done,
  output logic       o_wrap
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]    SEC_LAST   = 7'(SEC_MAX);
  localparam logic [6:0]    MIN_LAST   = 7'(MIN_MAX);
  localparam logic [6:0]    HOUR_LAST  = 7'(HOUR_MAX);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;

  logic [6:0] sec_nxt;
  logic [6:0] min_nxt;
  logic [6:0] hour_nxt;
  logic       roll;
  logic       limit_ok;
  logic       hit;

  // Value the fields take on the next tick, including the full rollover.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    sec_nxt  = o_sec;
    min_nxt  = o_min;
    hour_nxt = o_hour;
    roll     = 1'b0;
    if (o_sec < SEC_LAST) begin
      sec_nxt = o_sec + 7'd1;
    end else begin
      sec_nxt = '0;
      if (o_min < MIN_LAST) begin
        min_nxt = o_min + 7'd1;
      end else begin
        min_nxt = '0;
        if (o_hour < HOUR_LAST) begin
          hour_nxt = o_hour + 7'd1;
        end else begin
          hour_nxt = '0;
          roll     = 1'b1;
        end
      end
    end
  end

  // A target of 0:0:0 or any field beyond its terminal value means free-run.
  assign limit_ok = (i_limit_hour <= HOUR_LAST) && (i_limit_min <= MIN_LAST) &&
                    (i_limit_sec <= SEC_LAST) &&
                    ({i_limit_hour, i_limit_min, i_limit_sec} != 21'd0);

  // Match is judged on the post-increment value, with live limits.
  assign hit = limit_ok && (hour_nxt == i_limit_hour) &&
               (min_nxt == i_limit_min) && (sec_nxt == i_limit_sec);

  // Run-control FSM, prescaler, counters and registered output pulses.
  always_ff @(posedge i_clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state     <= IDLE;
      presc     <= '0;
      o_hour    <= '0;
      o_min     <= '0;
      o_sec     <= '0;
      o_running <= 1'b0;
      o_tick    <= 1'b0;
      o_done    <= 1'b0;
      o_wrap    <= 1'b0;
    end else begin
      o_tick <= 1'b0;
      o_done <= 1'b0;
      o_wrap <= 1'b0;
      if (i_clear) begin
        state     <= IDLE;
        presc     <= '0;
        o_hour    <= '0;
        o_min     <= '0;
        o_sec     <= '0;
        o_running <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!i_stop && i_start) begin
              state     <= RUN;
              presc     <= '0;
              o_running <= 1'b1;
            end
          end
          RUN: begin
            if (i_stop) begin
              // A tick due on this edge is dropped; prescaler holds.
              state     <= PAUSE;
              o_running <= 1'b0;
            end else if (presc == PRESC_LAST) begin
              presc  <= '0;
              o_hour <= hour_nxt;
              o_min  <= min_nxt;
              o_sec  <= sec_nxt;
              o_tick <= 1'b1;
              o_wrap <= roll;
              if (hit) begin
                state     <= DONE;
                o_running <= 1'b0;
                o_done    <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSE: begin
            // Resume keeps the paused prescaler phase.
            if (!i_stop && i_start) begin
              state     <= RUN;
              o_running <= 1'b1;
            end
          end
          default: begin
            // DONE is left only through i_clear or reset.
          end
        endcase
      end
    end
  end

endmodule
